// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register file and its load stager.
// Widths are derived from the lane count so both modules stay in step.
package vrf_pkg;

    typedef enum logic [1:0] {
        VRF_IDLE,
        VRF_LOAD,
        VRF_COMMIT
    } vrfState_t;

    function automatic int laneIndexWidth(int numLanes);
        return $clog2(numLanes);
    endfunction

    function automatic int countWidth(int numLanes);
        return $clog2(numLanes) + 1;
    endfunction

    // A zero count means a full row; oversized counts also saturate at a full row.
    function automatic int effectiveCount(int count, int numLanes);
        return (count == 0 || count > numLanes) ? numLanes : count;
    endfunction

    function automatic int laneLsb(int lane, int laneW);
        return lane * laneW;
    endfunction

endpackage

// File: rtl/vrf_load_stager.sv
// Lane-serial load engine: accepts beats over valid/ready, stages them, and
// presents the staged lanes as one masked row write for a single COMMIT cycle.
module vrf_load_stager
    import vrf_pkg::*;
#(
    parameter  int NUM_REGS  = 16,
    parameter  int LANE_W    = 32,
    parameter  int NUM_LANES = 4,
    localparam int ROW_W     = LANE_W * NUM_LANES,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int LANE_IW   = laneIndexWidth(NUM_LANES),
    localparam int CNT_W     = countWidth(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_start,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [LANE_IW-1:0]   ld_first_lane,
    input  logic [CNT_W-1:0]     ld_count,
    input  logic                 ld_valid,
    input  logic [LANE_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic                 ld_busy,
    output logic                 ld_done,
    output logic                 commitEn,
    output logic [ADDR_W-1:0]    commitAddr,
    output logic [NUM_LANES-1:0] commitMask,
    output logic [ROW_W-1:0]     commitData
);

    vrfState_t            state;
    logic [LANE_IW-1:0]   pointer;
    logic [CNT_W-1:0]     remaining;
    logic [ADDR_W-1:0]    targetAddr;
    logic [NUM_LANES-1:0] stageMask;
    logic [ROW_W-1:0]     stageData;

    // Handshake flags are registered alongside the state so they change exactly with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= VRF_IDLE;
            pointer    <= '0;
            remaining  <= '0;
            targetAddr <= '0;
            stageMask  <= '0;
            stageData  <= '0;
            ld_ready   <= 1'b0;
            ld_busy    <= 1'b0;
            ld_done    <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                VRF_IDLE: begin
                    if (ld_start) begin
                        targetAddr <= ld_addr;
                        pointer    <= ld_first_lane;
                        remaining  <= CNT_W'(effectiveCount(int'(ld_count), NUM_LANES));
                        stageMask  <= '0;
                        state      <= VRF_LOAD;
                        ld_ready   <= 1'b1;
                        ld_busy    <= 1'b1;
                    end
                end
                VRF_LOAD: begin
                    if (ld_valid) begin
                        stageData[laneLsb(int'(pointer), LANE_W) +: LANE_W] <= ld_data;
                        stageMask[pointer] <= 1'b1;
                        pointer   <= pointer + LANE_IW'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state    <= VRF_COMMIT;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                VRF_COMMIT: begin
                    state   <= VRF_IDLE;
                    ld_busy <= 1'b0;
                    ld_done <= 1'b1;
                end
                default: begin
                    state    <= VRF_IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign commitEn   = (state == VRF_COMMIT);
    assign commitAddr = targetAddr;
    assign commitMask = stageMask;
    assign commitData = stageData;

endmodule

// File: rtl/vector_regfile.sv
// Vector register file: row array with two combinational read ports, a masked
// direct write port and a lane-serial load port that commits whole rows.
module vector_regfile
    import vrf_pkg::*;
#(
    parameter  int NUM_REGS  = 16,
    parameter  int LANE_W    = 32,
    parameter  int NUM_LANES = 4,
    localparam int ROW_W     = LANE_W * NUM_LANES,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int LANE_IW   = laneIndexWidth(NUM_LANES),
    localparam int CNT_W     = countWidth(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    readAddress1,
    input  logic [ADDR_W-1:0]    readAddress2,
    output logic [ROW_W-1:0]     readData1,
    output logic [ROW_W-1:0]     readData2,
    input  logic                 writeEnable,
    input  logic [ADDR_W-1:0]    writeAddress,
    input  logic [NUM_LANES-1:0] writeLaneMask,
    input  logic [ROW_W-1:0]     writeData,
    input  logic                 ld_start,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [LANE_IW-1:0]   ld_first_lane,
    input  logic [CNT_W-1:0]     ld_count,
    input  logic                 ld_valid,
    input  logic [LANE_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic                 ld_busy,
    output logic                 ld_done
);

    logic [ROW_W-1:0]     rows [NUM_REGS];
    logic                 commitEn;
    logic [ADDR_W-1:0]    commitAddr;
    logic [NUM_LANES-1:0] commitMask;
    logic [ROW_W-1:0]     commitData;

    vrf_load_stager #(
        .NUM_REGS  (NUM_REGS),
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) loadStager (
        .clk           (clk),
        .reset         (reset),
        .ld_start      (ld_start),
        .ld_addr       (ld_addr),
        .ld_first_lane (ld_first_lane),
        .ld_count      (ld_count),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .commitEn      (commitEn),
        .commitAddr    (commitAddr),
        .commitMask    (commitMask),
        .commitData    (commitData)
    );

    // Per-lane merge: a committing load owns its staged lanes, the direct write gets the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rows[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (commitEn && commitAddr == ADDR_W'(r) && commitMask[l]) begin
                        rows[r][laneLsb(l, LANE_W) +: LANE_W] <= commitData[laneLsb(l, LANE_W) +: LANE_W];
                    end else if (writeEnable && writeAddress == ADDR_W'(r) && writeLaneMask[l]) begin
                        rows[r][laneLsb(l, LANE_W) +: LANE_W] <= writeData[laneLsb(l, LANE_W) +: LANE_W];
                    end
                end
            end
        end
    end

    assign readData1 = rows[readAddress1];
    assign readData2 = rows[readAddress2];

endmodule

// File: tb/tb_vector_regfile.sv
// Randomised self-checking bench for vector_regfile against a row-array model
// that applies direct writes and whole load transactions as they complete.
module tb_vector_regfile;

    localparam int NUM_REGS  = 16;
    localparam int LANE_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int ROW_W     = 128;
    localparam int ADDR_W    = 4;
    localparam int LANE_IW   = 2;
    localparam int CNT_W     = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [ADDR_W-1:0]    readAddress1, readAddress2;
    logic [ROW_W-1:0]     readData1, readData2;
    logic                 writeEnable;
    logic [ADDR_W-1:0]    writeAddress;
    logic [NUM_LANES-1:0] writeLaneMask;
    logic [ROW_W-1:0]     writeData;
    logic                 ld_start;
    logic [ADDR_W-1:0]    ld_addr;
    logic [LANE_IW-1:0]   ld_first_lane;
    logic [CNT_W-1:0]     ld_count;
    logic                 ld_valid;
    logic [LANE_W-1:0]    ld_data;
    logic                 ld_ready, ld_busy, ld_done;

    vector_regfile #(
        .NUM_REGS  (NUM_REGS),
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .readAddress1  (readAddress1),
        .readAddress2  (readAddress2),
        .readData1     (readData1),
        .readData2     (readData2),
        .writeEnable   (writeEnable),
        .writeAddress  (writeAddress),
        .writeLaneMask (writeLaneMask),
        .writeData     (writeData),
        .ld_start      (ld_start),
        .ld_addr       (ld_addr),
        .ld_first_lane (ld_first_lane),
        .ld_count      (ld_count),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [ROW_W-1:0]  model [NUM_REGS];
    logic [LANE_W-1:0] beatData [NUM_LANES];

    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] actual, input logic [ROW_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void modelWrite(int addr, logic [NUM_LANES-1:0] mask, logic [ROW_W-1:0] data);
        for (int l = 0; l < NUM_LANES; l++) begin
            if (mask[l]) model[addr][l*LANE_W +: LANE_W] = data[l*LANE_W +: LANE_W];
        end
    endfunction

    function automatic logic [ROW_W-1:0] randRow();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkRows(input string tag);
        for (int r = 0; r < NUM_REGS / 2; r++) begin
            readAddress1 = ADDR_W'(r);
            readAddress2 = ADDR_W'(r + NUM_REGS / 2);
            #1;
            checkOutput($sformatf("%s.row%0d", tag, r), readData1, model[r]);
            checkOutput($sformatf("%s.row%0d", tag, r + NUM_REGS / 2), readData2, model[r + NUM_REGS / 2]);
        end
    endtask

    task automatic applyStimulus(input int addr, input logic [NUM_LANES-1:0] mask, input logic [ROW_W-1:0] data);
        writeEnable   = 1'b1;
        writeAddress  = ADDR_W'(addr);
        writeLaneMask = mask;
        writeData     = data;
        tick();
        writeEnable = 1'b0;
        modelWrite(addr, mask, data);
    endtask

    // Drives a full load transaction; the optional direct write lands in the COMMIT cycle.
    task automatic runLoad(input int addr, input int first, input int cntField, input int stallPct,
                           input int stallCycle, input bit spuriousStart, input bit collide,
                           input int cAddr, input logic [NUM_LANES-1:0] cMask, input logic [ROW_W-1:0] cData);
        int n = (cntField == 0 || cntField > NUM_LANES) ? NUM_LANES : cntField;
        int accepted = 0;
        int ptr = first;
        int cyc = 0;
        bit v;
        logic [ROW_W-1:0]     stage = '0;
        logic [NUM_LANES-1:0] smask = '0;
        ld_start      = 1'b1;
        ld_addr       = ADDR_W'(addr);
        ld_first_lane = LANE_IW'(first);
        ld_count      = CNT_W'(cntField);
        tick();
        ld_start = 1'b0;
        checkOutput("ldBusyStart", ld_busy, 1'b1);
        while (accepted < n && cyc < 64) begin
            v = (cyc != stallCycle) && ($urandom_range(99) >= stallPct);
            checkOutput("ldReadyLoad", ld_ready, 1'b1);
            checkOutput("ldDoneLoad", ld_done, 1'b0);
            if (spuriousStart && cyc == 0) begin
                ld_start      = 1'b1;
                ld_addr       = ADDR_W'(addr ^ 1);
                ld_first_lane = LANE_IW'(first + 1);
                ld_count      = CNT_W'(1);
            end
            ld_valid = v;
            ld_data  = beatData[accepted];
            tick();
            cyc++;
            ld_start = 1'b0;
            ld_valid = 1'b0;
            if (v) begin
                stage[ptr*LANE_W +: LANE_W] = beatData[accepted];
                smask[ptr] = 1'b1;
                ptr = (ptr + 1) % NUM_LANES;
                accepted++;
            end
        end
        checkOutput("ldReadyCommit", ld_ready, 1'b0);
        checkOutput("ldDoneCommit", ld_done, 1'b0);
        checkOutput("ldBusyCommit", ld_busy, 1'b1);
        if (collide) begin
            writeEnable   = 1'b1;
            writeAddress  = ADDR_W'(cAddr);
            writeLaneMask = cMask;
            writeData     = cData;
        end
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        tick();
        writeEnable = 1'b0;
        ld_valid    = 1'b0;
        if (collide) modelWrite(cAddr, cMask, cData);
        modelWrite(addr, smask, stage);
        checkOutput("ldDonePulse", ld_done, 1'b1);
        checkOutput("ldBusyDone", ld_busy, 1'b0);
        checkOutput("ldReadyDone", ld_ready, 1'b0);
        checkRows("load");
        tick();
        checkOutput("ldDoneDrop", ld_done, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        readAddress1 = '0; readAddress2 = '0;
        writeEnable = 1'b0; writeAddress = '0; writeLaneMask = '0; writeData = '0;
        ld_start = 1'b0; ld_addr = '0; ld_first_lane = '0; ld_count = '0;
        ld_valid = 1'b0; ld_data = '0;
        for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
        tick();
        tick();
        reset = 1'b0;
        readAddress1 = 4'd0;
        readAddress2 = 4'd15;
        #1;
        checkOutput("resetRow0", readData1, '0);
        checkOutput("resetRow15", readData2, '0);
        checkOutput("resetBusy", ld_busy, 1'b0);
        checkOutput("resetReady", ld_ready, 1'b0);
        checkOutput("resetDone", ld_done, 1'b0);

        applyStimulus(3, 4'b0101, 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD);
        readAddress1 = 4'd3;
        #1;
        checkOutput("directRow3", readData1, 128'h0000_0000_BBBB_BBBB_0000_0000_DDDD_DDDD);
        applyStimulus(3, 4'b0000, randRow());
        checkRows("maskZero");

        beatData[0] = 32'h11; beatData[1] = 32'h22; beatData[2] = 32'h33; beatData[3] = 32'h44;
        runLoad(5, 2, 3, 0, 1, 1'b0, 1'b0, 0, '0, '0);
        readAddress1 = 4'd5;
        #1;
        checkOutput("loadRow5", readData1, 128'h00000022_00000011_00000000_00000033);

        beatData[0] = 32'h7000_0000; beatData[1] = 32'h7111_1111; beatData[2] = 32'h7222_2222; beatData[3] = 32'h7333_3333;
        runLoad(7, 1, 0, 0, -1, 1'b1, 1'b0, 0, '0, '0);

        beatData[0] = 32'hA0; beatData[1] = 32'hA1;
        runLoad(5, 0, 2, 0, -1, 1'b0, 1'b1, 5, 4'b0011, {4{32'hFF}});
        readAddress1 = 4'd5;
        #1;
        checkOutput("collideRow5", readData1, 128'h00000022_00000011_000000A1_000000A0);

        ld_start = 1'b1; ld_addr = 4'd2; ld_first_lane = 2'd0; ld_count = 3'd4;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h5555_5555;
        tick();
        tick();
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) model[r] = '0;
        checkOutput("abortBusy", ld_busy, 1'b0);
        checkOutput("abortReady", ld_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abortNoDone", ld_done, 1'b0);
            tick();
        end
        checkRows("abort");
        beatData[0] = 32'hC0; beatData[1] = 32'hC1; beatData[2] = 32'hC2; beatData[3] = 32'hC3;
        runLoad(2, 3, 4, 0, -1, 1'b0, 1'b0, 0, '0, '0);

        for (int it = 0; it < 20; it++) begin
            int la;
            int nw;
            la = $urandom_range(NUM_REGS - 1);
            nw = $urandom_range(3);
            for (int w = 0; w < nw; w++) begin
                applyStimulus($urandom_range(NUM_REGS - 1), NUM_LANES'($urandom_range(15)), randRow());
            end
            for (int l = 0; l < NUM_LANES; l++) beatData[l] = $urandom;
            runLoad(la, $urandom_range(NUM_LANES - 1), $urandom_range(7), 30, -1,
                    1'($urandom_range(1)), 1'($urandom_range(1)),
                    ($urandom_range(1) != 0) ? la : $urandom_range(NUM_REGS - 1),
                    NUM_LANES'($urandom_range(15)), randRow());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_regfile.md
# vector_regfile

Parametrised vector register file: `NUM_REGS` rows of `NUM_LANES` × `LANE_W` bits, with two asynchronous read ports. It has one direct write port with per-lane masking and a lane-serial memory-load port. The load port uses a valid/ready handshake and a small FSM. It stages incoming lanes and commits them to one row as a single masked write. The block is the successor to the fixed 16×128 row/column-addressed register set; it sits between the decode/execute stage (read and write ports) and the memory unit (load port).

## Interface
- `NUM_REGS`, 16, number of rows (power of two, ≥2)
- `LANE_W`, 32, lane width in bits
- `NUM_LANES`, 4, lanes per row (power of two, ≥2); derived `ROW_W = LANE_W*NUM_LANES`, `ADDR_W = $clog2(NUM_REGS)`, `LANE_IW = $clog2(NUM_LANES)`, `CNT_W = LANE_IW+1`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `readAddress1`, `readAddress2`  in  ADDR_W  read row selects
- `readData1`, `readData2`  out  ROW_W  combinational row contents (lane 0 = bits [LANE_W-1:0])
- `writeEnable`  in  1  direct row write this cycle
- `writeAddress`  in  ADDR_W  direct write row
- `writeLaneMask`  in  NUM_LANES  bit i enables lane i
- `writeData`  in  ROW_W  direct write data
- `ld_start`  in  1  begin a load (sampled only in IDLE)
- `ld_addr`  in  ADDR_W  target row, captured on accepted start
- `ld_first_lane`  in  LANE_IW  first lane written, captured on start
- `ld_count`  in  CNT_W  lanes to load; 0 means NUM_LANES; values >NUM_LANES clamp to NUM_LANES
- `ld_valid`  in  1  `ld_data` beat valid
- `ld_data`  in  LANE_W  one lane of load data
- `ld_ready`  out  1  block accepts a beat (high only in LOAD)
- `ld_busy`  out  1  state ≠ IDLE
- `ld_done`  out  1  one-cycle pulse: committed row is now readable

## Operation
- Reset: all rows ← 0, FSM ← IDLE, staging buffer/mask ← 0; `ld_ready`, `ld_busy`, `ld_done` = 0; `readData*` = 0 the cycle after reset is sampled.
- Direct write: on edge with `writeEnable`, lanes with mask bit set take `writeData` lanes; other lanes are unchanged. Mask 0 is a no-op.
- FSM IDLE: `ld_start` → capture addr/first lane/count, clear staging mask, → LOAD. `ld_start` is ignored outside IDLE.
- FSM LOAD: `ld_ready`=1. Each `ld_valid && ld_ready` edge writes the stage lane at the current pointer, sets its mask bit, increments the pointer modulo NUM_LANES (wraps 3→0), and decrements the remaining count. Acceptance of the last beat → COMMIT. `ld_valid` low stalls indefinitely.
- FSM COMMIT (1 cycle): `ld_ready`=0. At the edge, staged lanes are written to row `ld_addr` under the staging mask; unloaded lanes are preserved. → IDLE with `ld_done`=1 in the next cycle.
- Collision, commit and direct write on the same row in the same cycle: per lane, commit wins where the staging mask is set, and the direct write applies to the remaining masked lanes. Different rows: both writes occur.
- Reset mid-load: abort, discard the stage, no `ld_done`, all rows cleared.

## Timing
- Read latency 0 (combinational). A write at edge E is visible on `readData*` after E; there is no same-cycle bypass.
- Load of N lanes with `ld_valid` held high: `ld_start` sampled at edge T0. Beats are accepted at T1..TN, COMMIT occupies the cycle after TN, the row updates at edge TN+1, and `ld_done` is high for the cycle TN+1→TN+2. Total N+2 cycles from start to `ld_done`; the next `ld_start` may be given during the `ld_done` cycle.

## Structure
- Package `vrf_pkg`: FSM enum `{VRF_IDLE, VRF_LOAD, VRF_COMMIT}` and functions for derived widths and lane slicing.
- Sub-module `vrf_load_stager` holds the FSM, pointer/count, staging buffer and mask. It outputs commit_en/addr/mask/data. The top holds the array, the write merge and the read muxes.

## Test plan
- Reset, then read rows 0 and 15 → both read 0; `ld_busy`=0, `ld_ready`=0.
- Direct write row 3, mask 4'b0101, data 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD → row 3 = 128'h0000_0000_BBBB_BBBB_0000_0000_DDDD_DDDD the next cycle.
- Load row 5, first lane 2, count 3, beats 32'h11/32'h22/32'h33 with one ld_valid gap → lanes 2,3,0 = 11,22,33 and lane 1 unchanged; `ld_done` pulses once, 6 cycles after start (one stall included).
- Load count 0 into row 7 → all 4 lanes written; `ld_start` during LOAD is ignored (no restart, addr unchanged).
- Commit to row 5 lanes {0,1} and direct write row 5 mask 4'b0011 data lanes = 32'hFF in the same cycle → lane 0/1 hold load data; direct write lost only on those lanes.
- Assert reset after 2 of 4 beats → `ld_done` never pulses, all rows 0, FSM IDLE; a subsequent load completes normally.
